// File: rtl/xibus_pkg.sv
// xibus_pkg: shared states, error codes and default timeout for the XiBus master
package xibus_pkg;
  typedef enum logic [2:0] {IDLE, CHK, ADDR, DATA, RESP} state_e;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_STRB = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/xibus_wait_timer.sv
// xibus_wait_timer: saturating data-phase wait counter flagging the final allowed cycle
module xibus_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  // high while the current data cycle is the TIMEOUT-th one
  assign last_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/xibus_master_ctrl.sv
// xibus_master_ctrl: CPU-side XiBus transaction sequencer driving the address/data encoder
module xibus_master_ctrl
  import xibus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic [3:0]  cpu_write_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [1:0]  cpu_errcode_o,
  output logic [31:0] cpu_rdata_o,
  output logic        busy_o,
  output logic [3:0]  enc_write_o,
  output logic [31:0] enc_addr_o,
  output logic [31:0] enc_wdata_o,
  input  logic        enc_error_i,
  output logic        mst_adrcyn_o,
  output logic        cpu_masterd_o,
  input  logic [31:0] bus_ad_i,
  input  logic        bus_rdyn_i
);
  state_e      state_q, state_d;
  logic [3:0]  write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  errcode_q, errcode_d;
  logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d, adrcyn_q, adrcyn_d, md_q, md_d;
  logic        tmr_last;

  xibus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ADDR),
    .en_i   (state_q == DATA && bus_rdyn_i),
    .last_o (tmr_last)
  );

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    errcode_d = errcode_q;
    case (state_q)
      IDLE: if (cpu_req_i) begin
        state_d = CHK;
        write_d = cpu_write_i;
        addr_d  = cpu_addr_i;
        wdata_d = cpu_wdata_i;
      end
      CHK: begin
        state_d   = enc_error_i ? RESP : ADDR;
        errcode_d = enc_error_i ? ERR_STRB : errcode_q;
      end
      ADDR: state_d = DATA;
      DATA: if (!bus_rdyn_i) begin
        state_d   = RESP;
        errcode_d = ERR_OK;
        rdata_d   = (write_q == 4'b0) ? bus_ad_i : rdata_q;
      end else if (tmr_last) begin
        state_d   = RESP;
        errcode_d = ERR_TMO;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered against the next state so they line up with it
    ack_d    = state_d == RESP;
    err_d    = state_d == RESP && errcode_d != ERR_OK;
    busy_d   = state_d != IDLE;
    adrcyn_d = state_d != ADDR;
    md_d     = state_d == ADDR || (state_d == DATA && write_d != 4'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      write_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      errcode_q <= ERR_OK;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      adrcyn_q  <= 1'b1;
      md_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      errcode_q <= errcode_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      adrcyn_q  <= adrcyn_d;
      md_q      <= md_d;
    end
  end

  assign cpu_ack_o     = ack_q;
  assign cpu_err_o     = err_q;
  assign cpu_errcode_o = errcode_q;
  assign cpu_rdata_o   = rdata_q;
  assign busy_o        = busy_q;
  assign enc_write_o   = write_q;
  assign enc_addr_o    = addr_q;
  assign enc_wdata_o   = wdata_q;
  assign mst_adrcyn_o  = adrcyn_q;
  assign cpu_masterd_o = md_q;
endmodule

// File: tb/tb_xibus_master_ctrl.sv
// tb_xibus_master_ctrl: directed-vector bench for the XiBus master sequencer
module tb_xibus_master_ctrl;
  logic        clk = 1'b0;
  logic        rst, cpu_req_i, enc_error_i, bus_rdyn_i;
  logic [3:0]  cpu_write_i, enc_write_o;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o, enc_addr_o, enc_wdata_o, bus_ad_i;
  logic        cpu_ack_o, cpu_err_o, busy_o, mst_adrcyn_o, cpu_masterd_o;
  logic [1:0]  cpu_errcode_o;
  int          nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  // encoder model: only byte, halfword and word strobe patterns are legal
  assign enc_error_i = !(enc_write_o inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});

  xibus_master_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o),
    .cpu_err_o(cpu_err_o), .cpu_errcode_o(cpu_errcode_o), .cpu_rdata_o(cpu_rdata_o),
    .busy_o(busy_o), .enc_write_o(enc_write_o), .enc_addr_o(enc_addr_o),
    .enc_wdata_o(enc_wdata_o), .enc_error_i(enc_error_i), .mst_adrcyn_o(mst_adrcyn_o),
    .cpu_masterd_o(cpu_masterd_o), .bus_ad_i(bus_ad_i), .bus_rdyn_i(bus_rdyn_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals;
    chk("rst_ack", cpu_ack_o, 0);
    chk("rst_err", cpu_err_o, 0);
    chk("rst_code", cpu_errcode_o, 0);
    chk("rst_rdata", cpu_rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ewr", enc_write_o, 0);
    chk("rst_eaddr", enc_addr_o, 0);
    chk("rst_ewd", enc_wdata_o, 0);
    chk("rst_adrcyn", mst_adrcyn_o, 1);
    chk("rst_md", cpu_masterd_o, 0);
  endtask

  // waits: wait states before ready (-1 = never ready); cycle k is N+k
  task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                     input int waits, input logic [31:0] ad, input int exp_ack,
                     input logic [1:0] exp_code, input logic [31:0] exp_rdata);
    bit ill = exp_code == 2'b01;
    cpu_req_i = 1; cpu_write_i = w; cpu_addr_i = a; cpu_wdata_i = d;
    bus_ad_i = ad; bus_rdyn_i = 1;
    for (int k = 1; k <= exp_ack + 1; k++) begin
      tick();
      cpu_req_i = 0; cpu_write_i = 4'h0; cpu_addr_i = 32'hFFFF_FFFF; cpu_wdata_i = 0;
      bus_rdyn_i = !(waits >= 0 && k == 3 + waits);
      if (k == 1) begin
        chk("enc_addr", enc_addr_o, a);
        chk("enc_wdata", enc_wdata_o, d);
        chk("enc_write", enc_write_o, w);
      end
      chk($sformatf("adrcyn_k%0d", k), mst_adrcyn_o, !(k == 2 && !ill));
      chk($sformatf("md_k%0d", k), cpu_masterd_o, !ill && (k == 2 || (w != 0 && k >= 3 && k < exp_ack)));
      chk($sformatf("ack_k%0d", k), cpu_ack_o, k == exp_ack);
      chk($sformatf("busy_k%0d", k), busy_o, k <= exp_ack);
      if (k == exp_ack) begin
        chk("err", cpu_err_o, exp_code != 0);
        chk("errcode", cpu_errcode_o, exp_code);
        chk("rdata", cpu_rdata_o, exp_rdata);
      end
    end
    bus_rdyn_i = 1;
  endtask

  initial begin
    rst = 1; cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    bus_ad_i = 0; bus_rdyn_i = 1;
    tick(); tick();
    chk_reset_vals();
    rst = 0;
    tick();
    txn(4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, 4, 2'b00, 32'h0);
    txn(4'h0, 32'h0000_0040, 32'h0, 3, 32'h1234_5678, 7, 2'b00, 32'h1234_5678);
    txn(4'h5, 32'h0000_0080, 32'h5555_AAAA, -1, 32'h0, 2, 2'b01, 32'h1234_5678);
    txn(4'h0, 32'h0000_00C0, 32'h0, -1, 32'hFFFF_0000, 19, 2'b10, 32'h1234_5678);
    txn(4'h0, 32'h0000_0100, 32'h0, 15, 32'hCAFE_F00D, 19, 2'b00, 32'hCAFE_F00D);
    txn(4'h3, 32'h0000_0200, 32'h0BAD_F00D, -1, 32'h0, 19, 2'b10, 32'hCAFE_F00D);
    // reset in the middle of a data phase
    cpu_req_i = 1; cpu_write_i = 4'hF; cpu_addr_i = 32'h300; cpu_wdata_i = 32'h1111_2222;
    tick(); cpu_req_i = 0;
    tick(); tick();
    chk("pre_rst_busy", busy_o, 1);
    rst = 1;
    tick();
    chk_reset_vals();
    // reset and request together: request lost
    cpu_req_i = 1;
    tick();
    rst = 0; cpu_req_i = 0;
    tick();
    chk("lost_req_busy", busy_o, 0);
    chk("lost_req_eaddr", enc_addr_o, 0);
    txn(4'h1, 32'h0000_0400, 32'h0000_00AB, 1, 32'h0, 5, 2'b00, 32'h0);
    // back-to-back with req held high and target always ready
    cpu_req_i = 1; cpu_write_i = 4'hF; cpu_addr_i = 32'h500; cpu_wdata_i = 32'h5;
    bus_rdyn_i = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) cpu_req_i = 0;
      if (k == 4) chk("b2b_ack1", cpu_ack_o, 1);
      if (k == 5) chk("b2b_idle_busy", busy_o, 0);
      if (k == 5) chk("b2b_idle_ack", cpu_ack_o, 0);
      if (k == 6) chk("b2b_chk_busy", busy_o, 1);
      if (k == 6) chk("b2b_chk_adrcyn", mst_adrcyn_o, 1);
      if (k == 7) chk("b2b_addr_adrcyn", mst_adrcyn_o, 0);
      if (k == 9) chk("b2b_ack2", cpu_ack_o, 1);
      if (k == 10) chk("b2b_end_busy", busy_o, 0);
    end
    bus_rdyn_i = 1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
